// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM word and handshake state, plus the memory arbiter's
// grant state and port identifiers.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE,
        IGNT,
        DGNT
    } arb_state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } arb_port_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the memory arbiter and the RAM.
//   slave  : arbiter view (takes requests and RAM status, drives waits/loads/RAM)
//   master : requester + RAM view (drives requests and RAM status)
interface memory_arbiter_if;
    import cpu_types_pkg::*;

    // Instruction port
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    // Data port
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    // RAM side
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    // Error reporting
    logic      err;
    word_t     err_addr;
    logic      err_clr;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate, err_clr,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err, err_addr
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate, err_clr,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err, err_addr
    );

endinterface

// File: rtl/memory_arbiter.sv
// Sequential arbiter sharing one single-port RAM between the instruction-fetch
// and data ports. One access is granted at a time and held until the RAM
// answers ACCESS/ERROR or the cycle timeout expires; ties alternate ports.
// Ports:
//   CLK  : rising-edge clock
//   RST  : asynchronous active-high reset
//   bus  : memory_arbiter_if.slave (requests, waits/loads, RAM bus, err flags)
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter word_t       BADWORD = 32'hBAD1BAD1
) (
    input logic             CLK,
    input logic             RST,
    memory_arbiter_if.slave bus
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    typedef logic [CntW-1:0] cnt_t;
    localparam cnt_t CntMax = cnt_t'(TIMEOUT);

    arb_state_t state_q, state_d;
    arb_port_t  last_q, last_d;
    cnt_t       cnt_q, cnt_d;
    logic       err_q, err_d;
    word_t      err_addr_q, err_addr_d;

    logic  d_req, i_req, g_req;
    logic  hit, done, fail;
    word_t g_addr;

    // A simultaneous read+write on the data port counts as a write request.
    assign d_req  = bus.dREN | bus.dWEN;
    assign i_req  = bus.iREN;
    assign g_req  = (state_q == DGNT) ? d_req : ((state_q == IGNT) ? i_req : 1'b0);
    assign g_addr = (state_q == DGNT) ? bus.daddr : bus.iaddr;
    assign hit    = (bus.ramstate == ACCESS);
    // Done only while the granted port still requests; a dropped request aborts.
    assign done   = g_req & (hit | (bus.ramstate == ERROR) | (cnt_q == CntMax));
    // ACCESS wins if it lands on the timeout cycle.
    assign fail   = done & ~hit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            last_q     <= PORT_I;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    always_comb begin : next_state
        state_d    = state_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (d_req && (!i_req || last_q == PORT_I)) begin
                    state_d = DGNT;
                end else if (i_req) begin
                    state_d = IGNT;
                end
            end
            IGNT, DGNT: begin
                if (!g_req) begin
                    state_d = IDLE;
                end else if (done) begin
                    state_d = IDLE;
                    last_d  = (state_q == DGNT) ? PORT_D : PORT_I;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.err_clr) begin
            err_d      = 1'b0;
            err_addr_d = '0;
        end
        // A new failure overrides a same-cycle clear; only the first failure is kept.
        if (fail) begin
            err_d = 1'b1;
            if (!err_q || bus.err_clr) begin
                err_addr_d = g_addr;
            end
        end
    end

    always_comb begin : outputs
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = i_req;
        bus.dwait    = d_req;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.err      = err_q;
        bus.err_addr = err_addr_q;

        unique case (state_q)
            IGNT: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
                if (done) begin
                    bus.iwait = 1'b0;
                    bus.iload = fail ? BADWORD : bus.ramload;
                end
            end
            DGNT: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                if (done) begin
                    bus.dwait = 1'b0;
                    bus.dload = fail ? BADWORD : bus.ramload;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int unsigned TIMEOUT = 15;
    localparam word_t       BADWORD = 32'hBAD1BAD1;
    localparam int          MaxWait = 40;

    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   errors = 0;

    memory_arbiter_if bus ();

    memory_arbiter #(
        .TIMEOUT(TIMEOUT),
        .BADWORD(BADWORD)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    // RAM model: mode 0 answers ACCESS after ram_lat busy cycles, mode 1 never
    // answers, mode 2 answers ERROR after ram_lat cycles.
    int    ram_mode;
    int    ram_lat;
    int    ram_cnt;
    word_t ram_mem [0:255];

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            ram_cnt <= 0;
            for (int k = 0; k < 256; k++) ram_mem[k] <= '0;
        end else if (bus.ramREN || bus.ramWEN) begin
            if (bus.ramstate == ACCESS || bus.ramstate == ERROR) ram_cnt <= 0;
            else ram_cnt <= ram_cnt + 1;
            if (bus.ramstate == ACCESS && bus.ramWEN) ram_mem[bus.ramaddr[9:2]] <= bus.ramstore;
        end else begin
            ram_cnt <= 0;
        end
    end

    always_comb begin
        bus.ramstate = FREE;
        bus.ramload  = '0;
        if (bus.ramREN || bus.ramWEN) begin
            if (ram_mode == 0 && ram_cnt == ram_lat) begin
                bus.ramstate = ACCESS;
                if (bus.ramREN) bus.ramload = ram_mem[bus.ramaddr[9:2]];
            end else if (ram_mode == 2 && ram_cnt == ram_lat) begin
                bus.ramstate = ERROR;
            end else begin
                bus.ramstate = BUSY;
            end
        end
    end

    // Reference model: memory contents as seen by completed writes, and the last served port.
    word_t     ref_mem [0:255];
    arb_port_t ref_last;

    function automatic logic [7:0] idx(input word_t a);
        return a[9:2];
    endfunction

    function automatic word_t rand_addr();
        return word_t'($urandom_range(0, 15)) << 2;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic new_d_req();
        int k = int'($urandom_range(0, 2));
        bus.daddr  = rand_addr();
        bus.dstore = $urandom();
        bus.dWEN   = (k != 0);
        bus.dREN   = (k != 1);
    endtask

    // Drives one request on an otherwise idle arbiter; cyc is the cycle (IDLE = 0)
    // in which wait dropped, or -1 if it never did.
    task automatic run_access(input bit is_d, input bit we, input word_t addr, input word_t data,
                              output word_t load, output int cyc);
        cyc  = -1;
        load = '0;
        if (is_d) begin
            bus.dREN   = !we;
            bus.dWEN   = we;
            bus.daddr  = addr;
            bus.dstore = data;
        end else begin
            bus.iREN  = 1'b1;
            bus.iaddr = addr;
        end
        for (int c = 0; c < MaxWait; c++) begin
            @(negedge CLK);
            if ((is_d && !bus.dwait) || (!is_d && !bus.iwait)) begin
                load = is_d ? bus.dload : bus.iload;
                cyc  = c;
                break;
            end
            tick();
        end
        tick();
        bus.iREN = 1'b0;
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
        if (cyc >= 0) ref_last = is_d ? PORT_D : PORT_I;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        ram_mode = 0;
        ram_lat  = 3;
        bus.iREN = 1'b1;
        bus.iaddr = 32'h100;
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
        bus.daddr = '0;
        bus.dstore = '0;
        bus.err_clr = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || bus.ramaddr !== '0 ||
            bus.iwait !== 1'b1 || bus.err !== 1'b0 || bus.iload !== '0)
            $display("FAIL reset_state: ren=%b wen=%b addr=%h iwait=%b err=%b iload=%h want 0 0 0 1 0 0",
                     bus.ramREN, bus.ramWEN, bus.ramaddr, bus.iwait, bus.err, bus.iload);
        if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || bus.ramaddr !== '0 ||
            bus.iwait !== 1'b1 || bus.err !== 1'b0 || bus.iload !== '0) errors++;
        tick();
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.ramREN !== 1'b0 || bus.iwait !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: ren=%b iwait=%b want 0 1", bus.ramREN, bus.iwait);
        end
        tick();
        @(negedge CLK);
        checks++;
        if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h100 || bus.iwait !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: ren=%b addr=%h iwait=%b want 1 00000100 1",
                     bus.ramREN, bus.ramaddr, bus.iwait);
        end
        #1 RST = 1'b1;
        #1;
        checks++;
        if (bus.ramREN !== 1'b0 || bus.ramaddr !== '0 || bus.iwait !== 1'b1 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_access: ren=%b addr=%h iwait=%b err=%b want 0 0 1 0",
                     bus.ramREN, bus.ramaddr, bus.iwait, bus.err);
        end
        @(posedge CLK);
        #1;
        bus.iREN = 1'b0;
        RST = 1'b0;
        for (int k = 0; k < 256; k++) ref_mem[k] = '0;
        ref_last = PORT_I;
        tick();
    endtask

    // Both ports hold requests; served port must alternate and complete 1+lat cycles after IDLE.
    task automatic test_back_to_back(input int n, input bit rnd);
        int    lat;
        bit    exp_d;
        logic  exp_done, exp_iw, exp_dw, exp_ren, exp_wen;
        word_t exp_addr, got;
        ram_mode  = 0;
        bus.iREN  = 1'b1;
        bus.iaddr = rand_addr();
        new_d_req();
        for (int t = 0; t < n; t++) begin
            lat = rnd ? int'($urandom_range(0, 3)) : 0;
            ram_lat = lat;
            exp_d = (ref_last == PORT_I);
            for (int c = 0; c <= lat + 1; c++) begin
                @(negedge CLK);
                exp_done = (c == lat + 1);
                exp_iw   = !(exp_done && !exp_d);
                exp_dw   = !(exp_done && exp_d);
                checks++;
                if (bus.iwait !== exp_iw || bus.dwait !== exp_dw) begin
                    errors++;
                    $display("FAIL tie_waits t=%0d c=%0d: iwait=%b dwait=%b want %b %b",
                             t, c, bus.iwait, bus.dwait, exp_iw, exp_dw);
                end
                if (c == 0) begin
                    exp_ren = 1'b0;
                    exp_wen = 1'b0;
                    exp_addr = '0;
                end else begin
                    exp_ren  = exp_d ? (bus.dREN & ~bus.dWEN) : 1'b1;
                    exp_wen  = exp_d & bus.dWEN;
                    exp_addr = exp_d ? bus.daddr : bus.iaddr;
                end
                checks++;
                if (bus.ramREN !== exp_ren || bus.ramWEN !== exp_wen || bus.ramaddr !== exp_addr) begin
                    errors++;
                    $display("FAIL tie_ram t=%0d c=%0d: ren=%b wen=%b addr=%h want %b %b %h",
                             t, c, bus.ramREN, bus.ramWEN, bus.ramaddr, exp_ren, exp_wen, exp_addr);
                end
                if (c == 0) begin
                    checks++;
                    if (bus.iload !== '0 || bus.dload !== '0) begin
                        errors++;
                        $display("FAIL tie_idle_load t=%0d: iload=%h dload=%h want 0 0",
                                 t, bus.iload, bus.dload);
                    end
                end
                if (exp_done && !(exp_d && bus.dWEN)) begin
                    got = exp_d ? bus.dload : bus.iload;
                    checks++;
                    if (got !== ref_mem[idx(exp_addr)]) begin
                        errors++;
                        $display("FAIL tie_load t=%0d: got %h want %h", t, got, ref_mem[idx(exp_addr)]);
                    end
                end
                tick();
            end
            if (exp_d) begin
                if (bus.dWEN) ref_mem[idx(bus.daddr)] = bus.dstore;
                ref_last = PORT_D;
                new_d_req();
            end else begin
                ref_last = PORT_I;
                bus.iaddr = rand_addr();
            end
        end
        bus.iREN = 1'b0;
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        logic  exp_wen, exp_wait;
        word_t load;
        int    cyc, lat;
        ram_mode   = 0;
        ram_lat    = 2;
        bus.dWEN   = 1'b1;
        bus.daddr  = 32'h40;
        bus.dstore = 32'hCAFEF00D;
        for (int c = 0; c <= 4; c++) begin
            @(negedge CLK);
            exp_wen  = (c >= 1 && c <= 3);
            exp_wait = (c < 3);
            checks++;
            if (bus.ramWEN !== exp_wen || bus.dwait !== exp_wait || (c >= 1 && c <= 3 &&
                (bus.ramstore !== 32'hCAFEF00D || bus.ramaddr !== 32'h40))) begin
                errors++;
                $display("FAIL write_cycle c=%0d: wen=%b dwait=%b store=%h want %b %b cafef00d",
                         c, bus.ramWEN, bus.dwait, bus.ramstore, exp_wen, exp_wait);
            end
            tick();
            if (c == 3) bus.dWEN = 1'b0;
        end
        ref_mem[idx(32'h40)] = 32'hCAFEF00D;
        ref_last = PORT_D;

        lat = int'($urandom_range(0, 3));
        ram_lat = lat;
        run_access(1'b1, 1'b0, 32'h40, '0, load, cyc);
        checks++;
        if (cyc !== lat + 1 || load !== ref_mem[idx(32'h40)]) begin
            errors++;
            $display("FAIL read_back_d: cycle %0d load %h want %0d %h", cyc, load, lat + 1,
                     ref_mem[idx(32'h40)]);
        end
        lat = int'($urandom_range(0, 3));
        ram_lat = lat;
        run_access(1'b0, 1'b0, 32'h40, '0, load, cyc);
        checks++;
        if (cyc !== lat + 1 || load !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL read_back_i: cycle %0d load %h want %0d cafef00d", cyc, load, lat + 1);
        end
    endtask

    task automatic test_timeout();
        word_t load;
        int    cyc;
        ram_mode = 1;
        run_access(1'b1, 1'b0, 32'h80, '0, load, cyc);
        checks++;
        if (cyc !== int'(TIMEOUT) + 1 || load !== BADWORD) begin
            errors++;
            $display("FAIL timeout_d: cycle %0d load %h want %0d %h", cyc, load, TIMEOUT + 1, BADWORD);
        end
        checks++;
        if (bus.err !== 1'b1 || bus.err_addr !== 32'h80) begin
            errors++;
            $display("FAIL timeout_err: err=%b addr=%h want 1 00000080", bus.err, bus.err_addr);
        end
        run_access(1'b0, 1'b0, 32'h84, '0, load, cyc);
        checks++;
        if (cyc !== int'(TIMEOUT) + 1 || load !== BADWORD) begin
            errors++;
            $display("FAIL timeout_i: cycle %0d load %h want %0d %h", cyc, load, TIMEOUT + 1, BADWORD);
        end
        checks++;
        if (bus.err !== 1'b1 || bus.err_addr !== 32'h80) begin
            errors++;
            $display("FAIL second_fail_addr: err=%b addr=%h want 1 00000080", bus.err, bus.err_addr);
        end
        ram_mode = 0;
    endtask

    task automatic test_err_clr();
        ram_mode  = 2;
        ram_lat   = 1;
        bus.dREN  = 1'b1;
        bus.daddr = 32'hC0;
        tick();
        tick();
        bus.err_clr = 1'b1;
        @(negedge CLK);
        checks++;
        if (bus.dwait !== 1'b0 || bus.dload !== BADWORD) begin
            errors++;
            $display("FAIL error_resp: dwait=%b dload=%h want 0 %h", bus.dwait, bus.dload, BADWORD);
        end
        tick();
        bus.err_clr = 1'b0;
        bus.dREN = 1'b0;
        ref_last = PORT_D;
        checks++;
        if (bus.err !== 1'b1 || bus.err_addr !== 32'hC0) begin
            errors++;
            $display("FAIL fail_beats_clr: err=%b addr=%h want 1 000000c0", bus.err, bus.err_addr);
        end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        checks++;
        if (bus.err !== 1'b0 || bus.err_addr !== '0) begin
            errors++;
            $display("FAIL err_clear: err=%b addr=%h want 0 0", bus.err, bus.err_addr);
        end
        ram_mode = 0;
    endtask

    task automatic test_abort();
        ram_mode  = 0;
        ram_lat   = 10;
        bus.dREN  = 1'b1;
        bus.daddr = 32'h24;
        tick();
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h28;
        @(negedge CLK);
        checks++;
        if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h24 || bus.iwait !== 1'b1 || bus.dwait !== 1'b1) begin
            errors++;
            $display("FAIL abort_grant_d: ren=%b addr=%h iwait=%b dwait=%b want 1 00000024 1 1",
                     bus.ramREN, bus.ramaddr, bus.iwait, bus.dwait);
        end
        tick();
        bus.dREN = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.dwait !== 1'b0 || bus.dload !== '0 || bus.iwait !== 1'b1 || bus.ramREN !== 1'b0) begin
            errors++;
            $display("FAIL abort_drop: dwait=%b dload=%h iwait=%b ren=%b want 0 0 1 0",
                     bus.dwait, bus.dload, bus.iwait, bus.ramREN);
        end
        tick();
        @(negedge CLK);
        checks++;
        if (bus.ramREN !== 1'b0 || bus.iwait !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle: ren=%b iwait=%b want 0 1", bus.ramREN, bus.iwait);
        end
        tick();
        @(negedge CLK);
        checks++;
        if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h28 || bus.iwait !== 1'b1) begin
            errors++;
            $display("FAIL abort_then_i: ren=%b addr=%h iwait=%b want 1 00000028 1",
                     bus.ramREN, bus.ramaddr, bus.iwait);
        end
        tick();
        bus.iREN = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_back_to_back(4, 1'b0);
        test_write_read();
        test_timeout();
        test_err_clr();
        test_abort();
        test_back_to_back(12, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
